// File: rtl/serial_rx_cfg.sv
// UART receiver with configurable data/parity/stop bits; o_wr pulses one cycle after the last stop-bit sample.
// No backpressure: each frame is strobed once and its fields hold until the next strobe.
module serial_rx_cfg #(
  parameter int CLK_FREQ  = 16_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_wr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_perr,
  output logic                 o_ferr,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int   BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int   HALF      = BIT_TICKS / 2;
  localparam int   CW        = $clog2(BIT_TICKS) + 1;
  localparam int   IW        = $clog2(DATA_BITS + 1);
  localparam logic ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 low_q, low_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 wr_q, wr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 tick;

  assign rx_s = sync_q[1];
  assign tick = (cnt_q == CW'(BIT_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      low_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], i_rx};
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      low_q      <= low_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    par_d      = par_q;
    low_d      = low_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_d      = '0;
        stop_d     = 1'b0;
        par_d      = 1'b0;
        low_d      = 1'b1;
        ferr_acc_d = 1'b0;
        perr_acc_d = 1'b0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check: a line that has gone high again was only a glitch
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_s;
          low_d   = low_q & ~rx_s;
          bit_d   = bit_q + IW'(1);
          if (bit_q == IW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d      = '0;
          perr_acc_d = ((par_q ^ rx_s) != ODD);
          low_d      = low_q & ~rx_s;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d      = '0;
          stop_d     = 1'b1;
          ferr_acc_d = ferr_acc_q | ~rx_s;
          if (!stop_q) low_d = low_q & ~rx_s;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            wr_d    = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_acc_q | ~rx_s;
            brk_d   = stop_q ? low_q : (low_q & ~rx_s);
            state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_wr    = wr_q;
  assign o_data  = data_q;
  assign o_perr  = perr_q;
  assign o_ferr  = ferr_q;
  assign o_break = brk_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_cfg.sv
// Bench for serial_rx_cfg: three instances (8N1, 7E1, 8N2) driven by a bit-level serial transmitter.
module tb_serial_rx_cfg;
  localparam int CF   = 16_000;
  localparam int BR   = 1_200;
  localparam int BT   = CF / BR;
  localparam int HALF = BT / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx_a, rx_b, rx_c;
  logic wr_a, perr_a, ferr_a, brk_a, busy_a;
  logic wr_b, perr_b, ferr_b, brk_b, busy_b;
  logic wr_c, perr_c, ferr_c, brk_c, busy_c;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  rec_t got_a[$], got_b[$], got_c[$], exp_q[$];

  serial_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_wr(wr_a), .o_data(data_a),
    .o_perr(perr_a), .o_ferr(ferr_a), .o_break(brk_a), .o_busy(busy_a));
  serial_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_wr(wr_b), .o_data(data_b),
    .o_perr(perr_b), .o_ferr(ferr_b), .o_break(brk_b), .o_busy(busy_b));
  serial_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_c), .o_wr(wr_c), .o_data(data_c),
    .o_perr(perr_c), .o_ferr(ferr_c), .o_break(brk_c), .o_busy(busy_c));

  always @(negedge clk) begin
    if (wr_a === 1'b1) got_a.push_back({1'b0, data_a, perr_a, ferr_a, brk_a});
    if (wr_b === 1'b1) got_b.push_back({2'b0, data_b, perr_b, ferr_b, brk_b});
    if (wr_c === 1'b1) got_c.push_back({1'b0, data_c, perr_c, ferr_c, brk_c});
  end

  task automatic set_line(int sel, logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(int sel, logic v, int cyc);
    set_line(sel, v);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(int sel, int nb, logic [8:0] d, int pm, logic pb, int ns, logic s1, logic s2);
    hold(sel, 1'b0, BT);
    for (int i = 0; i < nb; i++) hold(sel, d[i], BT);
    if (pm != 0) hold(sel, pb, BT);
    hold(sel, s1, BT);
    if (ns == 2) hold(sel, s2, BT);
  endtask

  // Expected outcome of one frame, straight from the framing rules
  function automatic rec_t model(int nb, logic [8:0] d, int pm, logic pb, int ns, logic s1, logic s2);
    rec_t r;
    logic [8:0] m;
    int ones;
    m      = d & ((9'h1 << nb) - 9'h1);
    ones   = $countones(m);
    r.data = m;
    r.perr = (pm == 0) ? 1'b0 : (((ones + int'(pb)) % 2) != ((pm == 1) ? 1 : 0));
    r.ferr = !s1 || (ns == 2 && !s2);
    r.brk  = (m == 9'h0) && (pm == 0 || !pb) && !s1;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wr_a, data_a, perr_a, ferr_a, brk_a, busy_a} !== 13'h0) begin
      n_err++; $display("FAIL reset_a: got %0h expected 0", {wr_a, data_a, perr_a, ferr_a, brk_a, busy_a});
    end
    n_cmp++;
    if ({wr_b, data_b, perr_b, ferr_b, brk_b, busy_b} !== 12'h0) begin
      n_err++; $display("FAIL reset_b: got %0h expected 0", {wr_b, data_b, perr_b, ferr_b, brk_b, busy_b});
    end
    n_cmp++;
    if ({wr_c, data_c, perr_c, ferr_c, brk_c, busy_c} !== 13'h0) begin
      n_err++; $display("FAIL reset_c: got %0h expected 0", {wr_c, data_c, perr_c, ferr_c, brk_c, busy_c});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1_back_to_back();
    logic [8:0] d;
    got_a.delete(); exp_q.delete();
    for (int f = 0; f < 13; f++) begin
      d = (f == 0) ? 9'h04B : 9'($urandom_range(0, 255));
      send_frame(0, 8, d, 0, 1'b0, 1, 1'b1, 1'b1);
      exp_q.push_back(model(8, d, 0, 1'b0, 1, 1'b1, 1'b1));
      if ($urandom_range(0, 2) != 0) hold(0, 1'b1, $urandom_range(0, 15));
    end
    hold(0, 1'b1, 2 * BT);
    n_cmp++;
    if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL 8n1_count: got %0d strobes expected %0d", got_a.size(), exp_q.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_q[i]) begin
        n_err++; $display("FAIL 8n1_frame%0d: got d=%0h p=%0b f=%0b b=%0b expected d=%0h p=%0b f=%0b b=%0b", i,
          got_a[i].data, got_a[i].perr, got_a[i].ferr, got_a[i].brk, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr, exp_q[i].brk);
      end
    end
  endtask

  task automatic test_parity();
    logic [8:0] d;
    logic pb;
    got_b.delete(); exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      d  = (f < 2) ? 9'h041 : 9'($urandom_range(0, 127));
      pb = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      send_frame(1, 7, d, 2, pb, 1, 1'b1, 1'b1);
      exp_q.push_back(model(7, d, 2, pb, 1, 1'b1, 1'b1));
      hold(1, 1'b1, $urandom_range(0, 10));
    end
    hold(1, 1'b1, 2 * BT);
    n_cmp++;
    if (got_b.size() != exp_q.size()) begin
      n_err++; $display("FAIL parity_count: got %0d strobes expected %0d", got_b.size(), exp_q.size());
    end
    for (int i = 0; i < got_b.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_b[i] !== exp_q[i]) begin
        n_err++; $display("FAIL parity_frame%0d: got d=%0h p=%0b f=%0b b=%0b expected d=%0h p=%0b f=%0b b=%0b", i,
          got_b[i].data, got_b[i].perr, got_b[i].ferr, got_b[i].brk, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr, exp_q[i].brk);
      end
    end
  endtask

  task automatic test_stop2();
    logic [8:0] d;
    logic s1, s2;
    got_c.delete(); exp_q.delete();
    for (int f = 0; f < 10; f++) begin
      d  = ($urandom_range(0, 3) == 0) ? 9'h0 : 9'($urandom_range(0, 255));
      s1 = ($urandom_range(0, 2) != 0);
      s2 = ($urandom_range(0, 2) != 0);
      send_frame(2, 8, d, 0, 1'b0, 2, s1, s2);
      exp_q.push_back(model(8, d, 0, 1'b0, 2, s1, s2));
      hold(2, 1'b1, BT);
    end
    send_frame(2, 8, 9'h055, 0, 1'b0, 2, 1'b1, 1'b0);
    exp_q.push_back(model(8, 9'h055, 0, 1'b0, 2, 1'b1, 1'b0));
    hold(2, 1'b0, 3 * BT);
    n_cmp++;
    if (busy_c !== 1'b1) begin
      n_err++; $display("FAIL stop2_wait_high_busy: got %0b expected 1", busy_c);
    end
    hold(2, 1'b1, 4);
    n_cmp++;
    if (busy_c !== 1'b0) begin
      n_err++; $display("FAIL stop2_idle_after_high: got %0b expected 0", busy_c);
    end
    hold(2, 1'b1, BT);
    n_cmp++;
    if (got_c.size() != exp_q.size()) begin
      n_err++; $display("FAIL stop2_count: got %0d strobes expected %0d", got_c.size(), exp_q.size());
    end
    for (int i = 0; i < got_c.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_c[i] !== exp_q[i]) begin
        n_err++; $display("FAIL stop2_frame%0d: got d=%0h p=%0b f=%0b b=%0b expected d=%0h p=%0b f=%0b b=%0b", i,
          got_c[i].data, got_c[i].perr, got_c[i].ferr, got_c[i].brk, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr, exp_q[i].brk);
      end
    end
  endtask

  task automatic test_break();
    got_a.delete(); exp_q.delete();
    exp_q.push_back(model(8, 9'h0, 0, 1'b0, 1, 1'b0, 1'b0));
    exp_q.push_back(model(8, 9'h05A, 0, 1'b0, 1, 1'b1, 1'b1));
    hold(0, 1'b0, 15 * BT);
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++; $display("FAIL break_busy_while_low: got %0b expected 1", busy_a);
    end
    n_cmp++;
    if (got_a.size() != 1) begin
      n_err++; $display("FAIL break_single_strobe: got %0d strobes expected 1", got_a.size());
    end
    hold(0, 1'b1, 2 * BT);
    send_frame(0, 8, 9'h05A, 0, 1'b0, 1, 1'b1, 1'b1);
    hold(0, 1'b1, 2 * BT);
    n_cmp++;
    if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL break_count: got %0d strobes expected %0d", got_a.size(), exp_q.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_q[i]) begin
        n_err++; $display("FAIL break_frame%0d: got d=%0h p=%0b f=%0b b=%0b expected d=%0h p=%0b f=%0b b=%0b", i,
          got_a[i].data, got_a[i].perr, got_a[i].ferr, got_a[i].brk, exp_q[i].data, exp_q[i].perr, exp_q[i].ferr, exp_q[i].brk);
      end
    end
  endtask

  task automatic test_glitch();
    logic seen;
    int waited;
    got_a.delete();
    hold(0, 1'b0, 3);
    set_line(0, 1'b1);
    seen   = busy_a;
    waited = 0;
    while (busy_a !== 1'b0 && waited < HALF + 3) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++; $display("FAIL glitch_busy_seen: got %0b expected 1", seen);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++; $display("FAIL glitch_busy_cleared: got %0b expected 0 within %0d cycles", busy_a, HALF + 3);
    end
    hold(0, 1'b1, 2 * BT);
    n_cmp++;
    if (got_a.size() != 0) begin
      n_err++; $display("FAIL glitch_no_strobe: got %0d strobes expected 0", got_a.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] d;
    rec_t e;
    d = 9'h0A5;
    got_a.delete();
    hold(0, 1'b0, BT);
    for (int i = 0; i < 4; i++) hold(0, d[i], BT);
    hold(0, d[4], HALF);
    rst = 1'b1;
    hold(0, 1'b1, 2);
    n_cmp++;
    if ({wr_a, data_a, perr_a, ferr_a, brk_a, busy_a} !== 13'h0) begin
      n_err++; $display("FAIL midreset_outputs: got %0h expected 0", {wr_a, data_a, perr_a, ferr_a, brk_a, busy_a});
    end
    rst = 1'b0;
    hold(0, 1'b1, 2 * BT);
    send_frame(0, 8, 9'h03C, 0, 1'b0, 1, 1'b1, 1'b1);
    hold(0, 1'b1, 2 * BT);
    e = model(8, 9'h03C, 0, 1'b0, 1, 1'b1, 1'b1);
    n_cmp++;
    if (got_a.size() != 1) begin
      n_err++; $display("FAIL midreset_count: got %0d strobes expected 1", got_a.size());
    end
    if (got_a.size() > 0) begin
      n_cmp++;
      if (got_a[got_a.size() - 1] !== e) begin
        n_err++; $display("FAIL midreset_frame: got d=%0h expected d=%0h", got_a[got_a.size() - 1].data, e.data);
      end
    end
  endtask

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1; rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_8n1_back_to_back();
    test_parity();
    test_stop2();
    test_break();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_rx_cfg.md
SERIAL_RX_CFG -- requirements
Module: serial_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 16_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning bits per second.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1..2.
REQ-006 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port o_wr  output  1  one-cycle strobe: frame complete, outputs valid.
REQ-010 SHALL have port o_data  output  DATA_BITS  received data, LSB received first, bit 0 = first data bit.
REQ-011 SHALL have port o_perr  output  1  parity error for strobed frame; always 0 when PARITY=0.
REQ-012 SHALL have port o_ferr  output  1  framing error: any checked stop bit sampled low.
REQ-013 SHALL have port o_break  output  1  break: all data bits, parity bit (if any) and first stop bit sampled low.
REQ-014 SHALL have port o_busy  output  1  high from start-edge detect until return to IDLE.

Function
REQ-015 SHALL pass i_rx through a 2-flop synchronizer (reset to 1); all decisions use the synchronized value.
REQ-016 SHALL define BIT_TICKS = CLK_FREQ/BAUD_RATE (integer) and HALF = BIT_TICKS/2; tick counter width = $clog2(BIT_TICKS)+1.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE: synchronized line low -> START, counter cleared, o_busy=1.
REQ-019 START: after HALF ticks sample line; low -> DATA, high -> IDLE with no strobe (glitch reject).
REQ-020 Each subsequent bit SHALL be sampled once, exactly BIT_TICKS cycles after the previous sample.
REQ-021 DATA: shift DATA_BITS samples into shift register, LSB first; then PARITY if PARITY!=0, else STOP.
REQ-022 PARITY: o_perr computed as (XOR of data bits XOR parity sample) != (PARITY==1 ? 1 : 0).
REQ-023 STOP: sample STOP_BITS stop bits; o_ferr=1 if any sampled low.
REQ-024 On last stop sample SHALL assert o_wr for exactly one cycle on the next clock, with o_data, o_perr, o_ferr, o_break updated in that same cycle.
REQ-025 o_data, o_perr, o_ferr, o_break SHALL hold their values until the next o_wr.
REQ-026 After strobe: line high -> IDLE; line low (ferr or break) -> WAIT_HIGH, staying until line high, then IDLE; no new frame detected while in WAIT_HIGH.
REQ-027 With STOP_BITS=2 and first stop bit low, SHALL still sample second stop bit before strobing.
REQ-028 Falling edge arriving the cycle after return to IDLE SHALL be accepted (back-to-back frames, no idle gap required beyond stop bits).
REQ-029 o_busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-030 i_rst high at any clock edge SHALL force IDLE, clear counters and shift register, set synchronizer flops to 1, o_wr=0, o_data=0, o_perr=0, o_ferr=0, o_break=0, o_busy=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no strobe; reception resumes on the next falling edge after reset deasserts.

Verification (CLK_FREQ=16_000, BAUD_RATE=1_200: BIT_TICKS=13, HALF=6)
REQ-032 8N1, send "K" (0x4B) via serial_tx -> single o_wr pulse, o_data=0x4B, o_perr=0, o_ferr=0, o_break=0.
REQ-033 DATA_BITS=7, PARITY=2, send 0x41 with parity bit 1 (wrong) -> o_wr, o_data=0x41, o_perr=1; with parity bit 0 -> o_perr=0.
REQ-034 8N2, 0x55 with second stop bit low -> o_wr, o_data=0x55, o_ferr=1; FSM in WAIT_HIGH until line high.
REQ-035 Line held low 15 bit periods -> exactly one o_wr with o_data=0x00, o_break=1, o_ferr=1; no further strobe until line high then new frame.
REQ-036 Low glitch of 3 cycles on idle line -> no o_wr, o_busy returns to 0 within HALF+3 cycles.
REQ-037 i_rst pulsed during data bit 4 of 0xA5, then full 0x3C frame -> no strobe for 0xA5, one o_wr with o_data=0x3C.
